// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the instruction/stall inputs and the state/status outputs of the
//   microcode sequencer.
//   Signals:
//     instr      [15:0]        instruction register contents (opcode = [15:12])
//     stall                    freeze request
//     state      [7:0]         current microcode state code
//     instr_done               last-execute-state pulse
//     halted                   level, sequencer sits in HALT
//     illegal                  sticky undefined-opcode flag
//     retired    [RETIRE_W-1:0] completed-instruction count
//   Modports:
//     master - the sequencer (drives state and status)
//     slave  - the CPU/bench side (drives instr and stall)
interface control_sequencer_if #(
    parameter int unsigned RETIRE_W = 16
);
    logic [15:0]         instr;
    logic                stall;
    logic [7:0]          state;
    logic                instr_done;
    logic                halted;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  instr, stall,
        output state, instr_done, halted, illegal, retired
    );

    modport slave (
        output instr, stall,
        input  state, instr_done, halted, illegal, retired
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode state sequencer for the 16-bit CPU. Walks F0 -> F1 -> F2, then
//   decodes instr[15:12] into the execute-state sequence for that opcode and
//   returns to F0. Undefined opcodes (0xB-0xE) and halt park the sequencer in
//   HALT (0x3F) until reset.
//   Ports:
//     clk     in   system clock, rising edge
//     resetn  in   synchronous active-low reset (overrides stall)
//     bus     master modport of control_sequencer_if
//               instr/stall in; state/instr_done/halted/illegal/retired out
//   Parameters:
//     RETIRE_W  width of the retired-instruction counter (wraps)
module control_sequencer #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    control_sequencer_if.master  bus
);

    typedef enum logic [7:0] {
        S_F0     = 8'h00,
        S_F2     = 8'h01,
        S_LOAD   = 8'h02,
        S_MOVE   = 8'h03,
        S_LDPC   = 8'h04,
        S_BRANCH = 8'h05,
        S_SUB0   = 8'h06,
        S_SUB1   = 8'h07,
        S_SUB2   = 8'h08,
        S_ADD0   = 8'h09,
        S_ADD1   = 8'h0A,
        S_ADD2   = 8'h0B,
        S_XOR0   = 8'h0C,
        S_XOR1   = 8'h0D,
        S_XOR2   = 8'h0E,
        S_F1     = 8'h0F,
        S_PUSH0  = 8'h13,
        S_PUSH1  = 8'h14,
        S_PUSH2  = 8'h15,
        S_PUSH3  = 8'h16,
        S_POP0   = 8'h17,
        S_POP1   = 8'h18,
        S_POP2   = 8'h19,
        S_POP3   = 8'h1A,
        S_CALL0  = 8'h1B,
        S_CALL1  = 8'h1C,
        S_CALL2  = 8'h1D,
        S_CALL3  = 8'h1E,
        S_CALL4  = 8'h1F,
        S_CALL5  = 8'h20,
        S_RET0   = 8'h21,
        S_RET1   = 8'h22,
        S_RET2   = 8'h23,
        S_RET3   = 8'h24,
        S_CALL6  = 8'h25,
        S_HALT   = 8'h3F
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          opcode_q, opcode_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                last_exec;
    logic                done;

    // The opcode register is kept for debug visibility only; sequencing is
    // fully encoded in the state codes. Lower instr bits belong to the datapath.
    logic unused_bits;
    assign unused_bits = ^{opcode_q, bus.instr[11:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_F0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = S_F0;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        last_exec = 1'b0;

        case (state_q)
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: begin
                opcode_d = bus.instr[15:12];
                case (bus.instr[15:12])
                    4'h0: state_d = S_LOAD;
                    4'h1: state_d = S_MOVE;
                    4'h2: state_d = S_LDPC;
                    4'h3: state_d = S_BRANCH;
                    4'h4: state_d = S_SUB0;
                    4'h5: state_d = S_ADD0;
                    4'h6: state_d = S_XOR0;
                    4'h7: state_d = S_PUSH0;
                    4'h8: state_d = S_POP0;
                    4'h9: state_d = S_CALL0;
                    4'hA: state_d = S_RET0;
                    4'hF: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH,
            S_SUB2, S_ADD2, S_XOR2, S_PUSH3,
            S_POP3, S_CALL6, S_RET3: begin
                last_exec = 1'b1;
                state_d   = S_F0;
            end
            S_SUB0:  state_d = S_SUB1;
            S_SUB1:  state_d = S_SUB2;
            S_ADD0:  state_d = S_ADD1;
            S_ADD1:  state_d = S_ADD2;
            S_XOR0:  state_d = S_XOR1;
            S_XOR1:  state_d = S_XOR2;
            S_PUSH0: state_d = S_PUSH1;
            S_PUSH1: state_d = S_PUSH2;
            S_PUSH2: state_d = S_PUSH3;
            S_POP0:  state_d = S_POP1;
            S_POP1:  state_d = S_POP2;
            S_POP2:  state_d = S_POP3;
            S_CALL0: state_d = S_CALL1;
            S_CALL1: state_d = S_CALL2;
            S_CALL2: state_d = S_CALL3;
            S_CALL3: state_d = S_CALL4;
            S_CALL4: state_d = S_CALL5;
            S_CALL5: state_d = S_CALL6;
            S_RET0:  state_d = S_RET1;
            S_RET1:  state_d = S_RET2;
            S_RET2:  state_d = S_RET3;
            S_HALT:  state_d = S_HALT;
            // Corrupted codes recover to fetch without flagging illegal.
            default: state_d = S_F0;
        endcase

        // Stall freezes every register, including in fetch and HALT.
        if (bus.stall) begin
            state_d   = state_q;
            opcode_d  = opcode_q;
            illegal_d = illegal_q;
        end

        done      = last_exec & ~bus.stall;
        retired_d = retired_q + RETIRE_W'(done);
    end

    assign bus.state      = state_q;
    assign bus.instr_done = done;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic clk;
    logic resetn;
    logic resetn2;

    control_sequencer_if #(.RETIRE_W(16)) sif  ();
    control_sequencer_if #(.RETIRE_W(4))  sif2 ();

    control_sequencer #(.RETIRE_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    // Narrow counter instance so the wrap can be reached in few cycles.
    control_sequencer #(.RETIRE_W(4)) dut2 (
        .clk    (clk),
        .resetn (resetn2),
        .bus    (sif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic        stl;
        logic [7:0]  st;
        logic        done;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    logic [15:0] exp_ret;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input logic [15:0] ins, input logic stl,
                           input logic [7:0] st, input logic done,
                           input logic ill);
        exp_t e;
        e.ins  = ins;
        e.stl  = stl;
        e.st   = st;
        e.done = done;
        e.ill  = ill;
        sb.push_back(e);
    endtask

    // Expected states for a whole instruction, built from the opcode table.
    // instr carries random junk outside F2, since it must be ignored there.
    task automatic push_instr(input logic [15:0] ins, input logic stall_f1);
        logic [7:0] ex[$];
        ex = {};
        case (ins[15:12])
            4'h0: ex = {8'h02};
            4'h1: ex = {8'h03};
            4'h2: ex = {8'h04};
            4'h3: ex = {8'h05};
            4'h4: ex = {8'h06, 8'h07, 8'h08};
            4'h5: ex = {8'h09, 8'h0A, 8'h0B};
            4'h6: ex = {8'h0C, 8'h0D, 8'h0E};
            4'h7: ex = {8'h13, 8'h14, 8'h15, 8'h16};
            4'h8: ex = {8'h17, 8'h18, 8'h19, 8'h1A};
            4'h9: ex = {8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h25};
            4'hA: ex = {8'h21, 8'h22, 8'h23, 8'h24};
            default: ex = {};
        endcase
        add_exp(16'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
        if (stall_f1)
            add_exp(16'($urandom), 1'b1, 8'h0F, 1'b0, 1'b0);
        add_exp(16'($urandom), 1'b0, 8'h0F, 1'b0, 1'b0);
        add_exp(ins, 1'b0, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < ex.size(); i++)
            add_exp(16'($urandom), 1'b0, ex[i], (i == ex.size() - 1), 1'b0);
    endtask

    // Pops one expectation per cycle: drive its inputs, compare, clock.
    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            sif.instr = e.ins;
            sif.stall = e.stl;
            #1;
            tests++;
            if (sif.state !== e.st || sif.instr_done !== e.done ||
                sif.halted !== (e.st == 8'h3F) || sif.illegal !== e.ill ||
                sif.retired !== exp_ret) begin
                fails++;
                $display("FAIL %s: state=%h done=%b halted=%b illegal=%b retired=%h, expected state=%h done=%b halted=%b illegal=%b retired=%h",
                         tag, sif.state, sif.instr_done, sif.halted, sif.illegal, sif.retired,
                         e.st, e.done, (e.st == 8'h3F), e.ill, exp_ret);
            end
            if (e.done) exp_ret = exp_ret + 16'd1;
            step();
        end
        sif.stall = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        tests++;
        if (sif.state !== 8'h00 || sif.instr_done !== 1'b0 || sif.halted !== 1'b0 ||
            sif.illegal !== 1'b0 || sif.retired !== exp_ret) begin
            fails++;
            $display("FAIL %s: state=%h done=%b halted=%b illegal=%b retired=%h, expected state=00 done=0 halted=0 illegal=0 retired=%h",
                     tag, sif.state, sif.instr_done, sif.halted, sif.illegal, sif.retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        sif.stall = 1'b1;
        sif.instr = 16'h5120;
        step();
        step();
        exp_ret = '0;
        check_idle("reset");
        resetn    = 1'b1;
        sif.stall = 1'b0;
    endtask

    task automatic test_load();
        push_instr(16'h0123, 1'b0);
        drain("load");
        check_idle("load_end");
    endtask

    task automatic test_call();
        push_instr(16'h9000, 1'b0);
        drain("call");
        check_idle("call_end");
    endtask

    task automatic test_stall_add();
        add_exp(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h0F, 1'b0, 1'b0);
        add_exp(16'h5120, 1'b0, 8'h01, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h09, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b1, 8'h0A, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b1, 8'h0A, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h0A, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h0B, 1'b1, 1'b0);
        drain("stall_add");
        check_idle("stall_add_end");
    endtask

    task automatic test_back_to_back();
        push_instr(16'h1234, 1'b0);
        push_instr(16'h2FFF, 1'b0);
        push_instr(16'h3001, 1'b0);
        push_instr(16'h4ABC, 1'b0);
        push_instr(16'h6000, 1'b1);
        push_instr(16'h7777, 1'b0);
        push_instr(16'h8001, 1'b0);
        push_instr(16'hA555, 1'b0);
        drain("back_to_back");
        check_idle("back_to_back_end");
    endtask

    task automatic test_illegal();
        add_exp(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h0F, 1'b0, 1'b0);
        add_exp(16'hC000, 1'b0, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            add_exp(16'($urandom), (i == 5), 8'h3F, 1'b0, 1'b1);
        drain("illegal_halt");
        resetn = 1'b0;
        step();
        resetn  = 1'b1;
        exp_ret = '0;
        check_idle("illegal_reset");
    endtask

    task automatic test_reset_mid_push();
        push_instr(16'h0000, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h0F, 1'b0, 1'b0);
        add_exp(16'h7000, 1'b0, 8'h01, 1'b0, 1'b0);
        add_exp(16'h0000, 1'b0, 8'h13, 1'b0, 1'b0);
        drain("push_pre_reset");
        tests++;
        if (sif.state !== 8'h14 || sif.retired !== 16'd1) begin
            fails++;
            $display("FAIL push_in_14: state=%h retired=%h, expected state=14 retired=0001",
                     sif.state, sif.retired);
        end
        resetn    = 1'b0;
        sif.stall = 1'b1;
        step();
        exp_ret = '0;
        tests++;
        if (sif.state !== 8'h00 || sif.retired !== 16'd0 || sif.instr_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_push: state=%h retired=%h done=%b, expected state=00 retired=0000 done=0",
                     sif.state, sif.retired, sif.instr_done);
        end
        resetn    = 1'b1;
        sif.stall = 1'b0;
        push_instr(16'h1000, 1'b0);
        drain("after_reset");
        check_idle("after_reset_end");
    endtask

    task automatic test_retired_wrap();
        logic [7:0] seq[4];
        seq = '{8'h00, 8'h0F, 8'h01, 8'h03};
        sif2.instr = 16'h1000;
        sif2.stall = 1'b0;
        resetn2    = 1'b0;
        step();
        resetn2 = 1'b1;
        for (int i = 0; i < 15 * 4; i++) step();
        tests++;
        if (sif2.retired !== 4'hF || sif2.state !== 8'h00) begin
            fails++;
            $display("FAIL wrap_preload: retired=%h state=%h, expected retired=f state=00",
                     sif2.retired, sif2.state);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (sif2.state !== seq[i] || sif2.instr_done !== (i == 3) || sif2.retired !== 4'hF) begin
                fails++;
                $display("FAIL wrap_move: state=%h done=%b retired=%h, expected state=%h done=%b retired=f",
                         sif2.state, sif2.instr_done, sif2.retired, seq[i], (i == 3));
            end
            step();
        end
        tests++;
        if (sif2.retired !== 4'h0 || sif2.state !== 8'h00 || sif2.illegal !== 1'b0 ||
            sif2.halted !== 1'b0) begin
            fails++;
            $display("FAIL wrap_result: retired=%h state=%h illegal=%b halted=%b, expected retired=0 state=00 illegal=0 halted=0",
                     sif2.retired, sif2.state, sif2.illegal, sif2.halted);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_ret    = '0;
        resetn     = 1'b0;
        resetn2    = 1'b0;
        sif.instr  = '0;
        sif.stall  = 1'b0;
        sif2.instr = '0;
        sif2.stall = 1'b0;
        test_reset();
        test_load();
        test_call();
        test_stall_add();
        test_back_to_back();
        test_illegal();
        test_reset_mid_push();
        test_retired_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
